// File: rtl/irq_prio_pkg.sv
// irq_prio_pkg: shared types, defaults and width helper for irq_prio_ctrl.
// Optional TMR hardening is selected with the IRQ_PRIO_TMR_EN macro.
package irq_prio_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } irq_state_e;

    localparam int IRQ_NUM_GRP_DEF = 3;
    localparam int IRQ_NUM_CH_DEF  = 9;

    // Index width for n items, never narrower than one bit.
    function automatic int irq_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/irq_tmr_vote.sv
// irq_tmr_vote: bitwise 2-of-3 majority voter with disagreement flag.
// Only instantiated when IRQ_PRIO_TMR_EN is defined.
module irq_tmr_vote #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    output logic [WIDTH-1:0] y_o,
    output logic             mis_o
);

    assign y_o   = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    assign mis_o = |((a_i ^ b_i) | (a_i ^ c_i));

endmodule

// File: rtl/irq_prio_ctrl.sv
// irq_prio_ctrl: edge-captured, masked, fixed-priority interrupt presenter.
// Define IRQ_PRIO_TMR_EN to triplicate and vote the FSM/winner registers.
module irq_prio_ctrl
    import irq_prio_pkg::*;
#(
    parameter  int NUM_GRP = IRQ_NUM_GRP_DEF,
    parameter  int NUM_CH  = IRQ_NUM_CH_DEF,
    localparam int GRP_W   = irq_width(NUM_GRP),
    localparam int CH_W    = irq_width(NUM_CH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_GRP*NUM_CH-1:0] req_i,
    input  logic [NUM_CH-1:0]         en_i,
    input  logic                      ack_i,
    output logic                      irq_o,
    output logic [GRP_W-1:0]          irq_grp_o,
    output logic [CH_W-1:0]           irq_ch_o,
    output logic [NUM_GRP*NUM_CH-1:0] pend_o,
    output logic                      tmr_err_o
);

    localparam int N  = NUM_GRP * NUM_CH;
    localparam int BW = 2 + 1 + GRP_W + CH_W;

    logic [N-1:0]     req_q, pend_q, pend_d, elig, clr;
    logic [BW-1:0]    cur_v, nxt_d;
    irq_state_e       st_v, st_d;
    logic             irq_v, irq_d;
    logic [GRP_W-1:0] grp_v, grp_d, win_grp;
    logic [CH_W-1:0]  ch_v, ch_d, win_ch;
    logic             win_any;
    logic             pres_ack;
    int               win_idx;

    // Lowest group first, then lowest channel; scan high-to-low so the
    // last hit kept is the highest-priority one.
    function automatic logic [GRP_W+CH_W:0] pick(input logic [N-1:0] e);
        logic [GRP_W+CH_W:0] r;
        r = '0;
        for (int g = NUM_GRP - 1; g >= 0; g--) begin
            for (int c = NUM_CH - 1; c >= 0; c--) begin
                if (e[g*NUM_CH+c]) begin
                    r = {1'b1, GRP_W'(g), CH_W'(c)};
                end
            end
        end
        return r;
    endfunction

    assign elig = pend_q & {NUM_GRP{en_i}};
    assign {win_any, win_grp, win_ch} = pick(elig);

    assign st_v  = irq_state_e'(cur_v[BW-1 -: 2]);
    assign irq_v = cur_v[BW-3];
    assign grp_v = cur_v[CH_W +: GRP_W];
    assign ch_v  = cur_v[CH_W-1:0];
    assign nxt_d = {st_d, irq_d, grp_d, ch_d};

    assign pres_ack = (st_v == PRESENT) && ack_i;
    assign win_idx  = int'(grp_v) * NUM_CH + int'(ch_v);

    // One-hot clear of the presented bit when it is acknowledged.
    always_comb begin
        clr = '0;
        for (int i = 0; i < N; i++) begin
            clr[i] = pres_ack && (i == win_idx);
        end
    end

    // A new edge in the same cycle as the clear keeps the bit pending.
    assign pend_d = (pend_q & ~clr) | (req_i & ~req_q);

    // Request edge detector and sticky pending bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q  <= '0;
            pend_q <= '0;
        end else begin
            req_q  <= req_i;
            pend_q <= pend_d;
        end
    end

    // Presentation FSM next state; winner is frozen while presenting.
    always_comb begin
        st_d  = st_v;
        irq_d = irq_v;
        grp_d = grp_v;
        ch_d  = ch_v;
        unique case (st_v)
            IDLE: begin
                if (win_any) begin
                    st_d  = PRESENT;
                    irq_d = 1'b1;
                    grp_d = win_grp;
                    ch_d  = win_ch;
                end
            end
            PRESENT: begin
                if (ack_i) begin
                    st_d  = GAP;
                    irq_d = 1'b0;
                end
            end
            GAP: begin
                st_d = IDLE;
            end
            default: begin
                st_d  = IDLE;
                irq_d = 1'b0;
            end
        endcase
    end

`ifdef IRQ_PRIO_TMR_EN
    logic [BW-1:0] cp0_q, cp1_q, cp2_q;
    logic          mis;
    logic          tmr_err_q;

    // Three copies reload from the voted next state, scrubbing upsets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cp0_q     <= '0;
            cp1_q     <= '0;
            cp2_q     <= '0;
            tmr_err_q <= 1'b0;
        end else begin
            cp0_q     <= nxt_d;
            cp1_q     <= nxt_d;
            cp2_q     <= nxt_d;
            tmr_err_q <= mis;
        end
    end

    irq_tmr_vote #(
        .WIDTH (BW)
    ) u_vote (
        .a_i   (cp0_q),
        .b_i   (cp1_q),
        .c_i   (cp2_q),
        .y_o   (cur_v),
        .mis_o (mis)
    );

    assign tmr_err_o = tmr_err_q;
`else
    logic [BW-1:0] cp_q;

    // Single copy of the FSM state and presented winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cp_q <= '0;
        end else begin
            cp_q <= nxt_d;
        end
    end

    assign cur_v     = cp_q;
    assign tmr_err_o = 1'b0;
`endif

    assign irq_o     = irq_v;
    assign irq_grp_o = grp_v;
    assign irq_ch_o  = ch_v;
    assign pend_o    = pend_q;

endmodule
